mux_nto1_rr: RTL and testbench
==============================

MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

Interface
REQ-001 Parameter NCH, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 Derived localparam SW = clog2(NCH): width of the select and index fields.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  NCH*W  channel i occupies bits [i*W +: W].
REQ-007 in_valid  input  NCH  per-channel data-valid.
REQ-008 in_ready  output  NCH  per-channel accept strobe, combinational.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 select  input  SW  channel index used in fixed mode.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_sel  output  SW  registered index of the channel held in out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 load_en SHALL equal (!out_valid | out_ready); the one-deep output register SHALL accept a new word only when load_en is 1.
REQ-016 Fixed mode: the candidate channel SHALL be the one indexed by select, and it SHALL be granted only if in_valid[select] is 1.
REQ-017 Fixed mode with select >= NCH: no channel SHALL be granted, and in_ready SHALL be all zeros.
REQ-018 Round-robin mode: the grant SHALL go to the first channel with in_valid set, searching from (ptr+1) mod NCH upward and wrapping past NCH-1 to 0.
REQ-019 ptr SHALL update to the granted index only on a transfer (grant & load_en); it SHALL update in both modes.
REQ-020 in_ready[i] SHALL equal (grant == i) & load_en; at most one in_ready bit SHALL be high per cycle.
REQ-021 On a transfer, out_data and out_sel SHALL load the granted channel's data and index on the next edge, and out_valid SHALL be 1 (latency 1 cycle).
REQ-022 When out_valid & out_ready and no grant exists, out_valid SHALL clear on the next edge; out_data and out_sel SHALL hold their values.
REQ-023 When out_valid & !out_ready, out_data, out_sel and out_valid SHALL hold, and in_ready SHALL be all zeros (backpressure).
REQ-024 Simultaneous drain and refill SHALL sustain one word per cycle with no bubble.
REQ-025 Changes to mode or select SHALL affect only the next arbitration and SHALL never alter a word already held.
REQ-026 A channel whose in_valid drops without a transfer SHALL neither be granted nor move ptr.

Reset
REQ-027 While rst is high on an edge: out_valid = 0, out_data = 0, out_sel = 0, ptr = NCH-1, so the first round-robin priority is channel 0.
REQ-028 While rst is high, in_ready SHALL be all zeros.
REQ-029 Reset asserted mid-operation SHALL discard any held word; no transfer SHALL be reported for that cycle.

Verification
REQ-030 NCH=4, W=8, mode=0, select=2, in_data lane2=0xA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_sel=2, out_valid=1.
REQ-031 mode=1, all in_valid=1, out_ready=1 held, from reset -> out_sel sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-032 mode=1, in_valid=4'b1001, ptr=0 -> grant 3, then grant 0 (wrap-around).
REQ-033 out_valid=1, out_ready=0 for 3 cycles with new inputs valid -> in_ready=0 and out_data unchanged; out_ready=1 -> next word loads in the following cycle.
REQ-034 mode=0, select=3, in_valid=4'b0111 -> no grant, in_ready=0; out_valid falls after drain.
REQ-035 rst=1 for one cycle while out_valid=1 -> next cycle out_valid=0, out_data=0; first round-robin grant afterwards goes to the lowest valid channel from 0.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// N-to-1 channel multiplexer with one-deep registered output.
// Selects a channel either by fixed index or by round-robin rotation.
module mux_nto1_rr #(
  parameter int NCH = 4,
  parameter int W   = 8,
  localparam int SW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    select,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SW-1:0] ptr;
  logic          load_en;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          fix_found;
  logic          xfer;

  assign load_en = !out_valid || out_ready;

  // First valid channel at or after ptr+1, wrapping modulo NCH.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      int unsigned   cand;
      logic [SW-1:0] cand_idx;
      cand     = (int'(ptr) + k) % NCH;
      cand_idx = SW'(cand);
      if (!rr_found && in_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    fix_found = 1'b0;
    if (int'(select) < NCH) begin
      fix_found = in_valid[select];
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_vld = rr_found;
      grant_idx = rr_idx;
    end else begin
      grant_vld = fix_found;
      grant_idx = select;
    end
  end

  // Reset suppresses the transfer so no in_ready strobe is reported that cycle.
  assign xfer = grant_vld && load_en && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(NCH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*W +: W];
      out_sel   <= grant_idx;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: directed vector table plus
// randomized traffic checked against a behavioural model.
module tb_mux_nto1_rr;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int SW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode;
  logic [SW-1:0]    select;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_sel;
  logic             out_valid;
  logic             out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mux_nto1_rr #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .select(select),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] vld;
    logic           ordy;
    logic [NCH-1:0] e_rdy;
    logic           e_ov;
    logic [SW-1:0]  e_os;
    logic [W-1:0]   e_od;
  } vec_t;

  vec_t tbl[18];

  logic [NCH-1:0] obs_rdy;
  logic           obs_ov;
  logic [SW-1:0]  obs_os;
  logic [W-1:0]   obs_od;

  // Behavioural model state
  bit       m_ov;
  int       m_os;
  int       m_od;
  int       m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drives one cycle of inputs; samples in_ready mid-cycle and the
  // registered outputs shortly after the following edge.
  task automatic run_cycle(input logic r, input logic md, input logic [SW-1:0] s,
                           input logic [NCH-1:0] v, input logic [NCH*W-1:0] d,
                           input logic ordy);
    rst = r; mode = md; select = s; in_valid = v; in_data = d; out_ready = ordy;
    #2;
    obs_rdy = in_ready;
    @(posedge clk);
    #1;
    obs_ov = out_valid;
    obs_os = out_sel;
    obs_od = out_data;
  endtask

  // Model: returns granted channel or -1, from the arbitration rules.
  function automatic int model_grant(input logic md, input int s, input logic [NCH-1:0] v);
    int order[$];
    if (!md) begin
      if (s < NCH && v[s]) return s;
      return -1;
    end
    for (int k = 1; k <= NCH; k++) order.push_back((m_ptr + k) % NCH);
    foreach (order[i]) if (v[order[i]]) return order[i];
    return -1;
  endfunction

  initial begin
    logic [NCH*W-1:0] dconst;
    dconst = {8'h44, 8'hA5, 8'h22, 8'h11};

    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[2]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    tbl[12] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    tbl[13] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    tbl[14] = '{1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h22};
    tbl[15] = '{1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h22};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[17] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};

    rst = 1'b1; mode = 1'b0; select = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_cycle(tbl[i].rst, tbl[i].mode, tbl[i].sel, tbl[i].vld, dconst, tbl[i].ordy);
      chk($sformatf("vec%0d in_ready", i), 32'(obs_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d out_valid", i), 32'(obs_ov), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_sel", i), 32'(obs_os), 32'(tbl[i].e_os));
      chk($sformatf("vec%0d out_data", i), 32'(obs_od), 32'(tbl[i].e_od));
    end

    // After a mid-run reset the first round-robin grant is the lowest valid from 0.
    run_cycle(1'b0, 1'b1, 2'd0, 4'b0110, dconst, 1'b1);
    chk("post_rst rr in_ready", 32'(obs_rdy), 32'h2);
    chk("post_rst rr out_sel", 32'(obs_os), 32'd1);
    chk("post_rst rr out_data", 32'(obs_od), 32'h22);

    // Randomized traffic against the model, starting from reset.
    m_ov = 1'b0; m_os = 0; m_od = 0; m_ptr = NCH - 1;
    for (int unsigned c = 0; c < 3000; c++) begin
      logic             r, md, ordy;
      logic [SW-1:0]    s;
      logic [NCH-1:0]   v, e_rdy;
      logic [NCH*W-1:0] d;
      int               g;
      bit               load_en;
      r    = (c == 0) || ($urandom_range(0, 59) == 0);
      md   = 1'($urandom);
      s    = SW'($urandom);
      v    = NCH'($urandom);
      d    = ($urandom);
      ordy = ($urandom_range(0, 3) != 0);

      g       = model_grant(md, int'(s), v);
      load_en = !m_ov || ordy;
      e_rdy   = '0;
      if (!r && g >= 0 && load_en) e_rdy[g] = 1'b1;

      run_cycle(r, md, s, v, d, ordy);

      if (r) begin
        m_ov = 1'b0; m_os = 0; m_od = 0; m_ptr = NCH - 1;
      end else if (e_rdy != '0) begin
        m_ov = 1'b1; m_os = g; m_od = int'(d[g*W +: W]); m_ptr = g;
      end else if (ordy) begin
        m_ov = 1'b0;
      end

      chk("rand in_ready", 32'(obs_rdy), 32'(e_rdy));
      chk("rand out_valid", 32'(obs_ov), 32'(m_ov));
      chk("rand out_sel", 32'(obs_os), 32'(m_os));
      chk("rand out_data", 32'(obs_od), 32'(m_od));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
